dmem_port_ctrl: RTL and testbench

- Memory-side responder for MEM-stage data accesses.
- Accepts one request at a time over a valid/ready handshake and drives a word-wide single-port synchronous data RAM.
- Loads: performs byte/halfword extraction with zero- or sign-extension.
- Partial stores: performs read-modify-write. Raises stall via req_ready and reports alignment/encoding errors.

---
 rtl/dmem_port_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_dmem_port_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_ctrl.sv
// dmem_port_ctrl: memory-side responder for MEM-stage data accesses.
//
// Takes one request at a time over a valid/ready handshake and drives a
// word-wide single-port synchronous RAM (read data returned the cycle after
// the read enable). Loads extract a byte/halfword lane with zero or sign
// extension. Partial stores are done as read-modify-write. Misaligned or
// illegal requests get an error response without touching the RAM.
//
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake; ready only while idle
//   req_addr             byte address
//   req_access           access code (ld_w/ld_b/ld_bu/ld_h/ld_hu/st_w/st_b/st_h)
//   req_wdata            right-aligned store data
//   resp_valid           one-cycle response pulse
//   resp_rdata           extended load data, 0 for stores, ERR_RDATA on error
//   resp_err             misaligned or illegal access
//   mem_en/mem_we        RAM enable / whole-word write enable
//   mem_addr             RAM word address (req_addr[ADDR_W+1:2])
//   mem_wdata/mem_rdata  RAM write / read data
//
// Optional build macro DMEM_STAT_EN adds saturating statistics outputs
// stat_ld, stat_st, stat_rmw and stat_err.

module dmem_port_ctrl #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] ERR_RDATA = 32'h0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [3:0]        req_access,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef DMEM_STAT_EN
  ,
  output logic [31:0]       stat_ld,
  output logic [31:0]       stat_st,
  output logic [31:0]       stat_rmw,
  output logic [31:0]       stat_err
`endif
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRd   = 3'd1;
  localparam logic [2:0] StRdw  = 3'd2;
  localparam logic [2:0] StWr   = 3'd3;
  localparam logic [2:0] StResp = 3'd4;

  localparam logic [1:0] SzB = 2'd0;
  localparam logic [1:0] SzH = 2'd1;
  localparam logic [1:0] SzW = 2'd2;

  typedef struct packed {
    logic       legal;
    logic       load;
    logic       sgn;
    logic [1:0] size;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] code);
    dec_t d;
    d = '0;
    case (code)
      4'b0110: d = '{legal: 1'b1, load: 1'b1, sgn: 1'b0, size: SzW};
      4'b0001: d = '{legal: 1'b1, load: 1'b1, sgn: 1'b0, size: SzB};
      4'b0010: d = '{legal: 1'b1, load: 1'b1, sgn: 1'b1, size: SzB};
      4'b0100: d = '{legal: 1'b1, load: 1'b1, sgn: 1'b0, size: SzH};
      4'b1000: d = '{legal: 1'b1, load: 1'b1, sgn: 1'b1, size: SzH};
      4'b1001: d = '{legal: 1'b1, load: 1'b0, sgn: 1'b0, size: SzW};
      4'b0011: d = '{legal: 1'b1, load: 1'b0, sgn: 1'b0, size: SzB};
      4'b1100: d = '{legal: 1'b1, load: 1'b0, sgn: 1'b0, size: SzH};
      default: d = '0;
    endcase
    return d;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [3:0]        acc_q, acc_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;    // load result or merged store word
  logic              err_q, err_d;

  dec_t in_dec, q_dec;
  logic in_misalign;

  // Only the word-address bits (plus lane offset) are meaningful to this port.
  logic unused_addr_hi;
  logic unused_q_legal;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign unused_q_legal = q_dec.legal;

  assign in_dec = decode(req_access);
  assign q_dec  = decode(acc_q);

  assign in_misalign = ((in_dec.size == SzW) && (req_addr[1:0] != 2'b00)) ||
                       ((in_dec.size == SzH) && req_addr[0]);

  // Lane extraction and merge operate on the RAM word arriving in StRdw.
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_val;
  logic [31:0] merged;

  always_comb begin
    rd_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (q_dec.size)
      SzB:     ld_val = {{24{q_dec.sgn & rd_byte[7]}}, rd_byte};
      SzH:     ld_val = {{16{q_dec.sgn & rd_half[15]}}, rd_half};
      default: ld_val = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    case (q_dec.size)
      SzB:     merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      SzH:     merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        // req_ready is high throughout StIdle, so valid alone means accept.
        if (req_valid) begin
          addr_d  = req_addr[ADDR_W+1:0];
          acc_d   = req_access;
          wdata_d = req_wdata;
          data_d  = '0;
          err_d   = !in_dec.legal || in_misalign;
          if (!in_dec.legal || in_misalign) begin
            state_d = StResp;
          end else if (!in_dec.load && (in_dec.size == SzW)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: state_d = StRdw;
      StRdw: begin
        if (q_dec.load) begin
          data_d  = ld_val;
          state_d = StResp;
        end else begin
          data_d  = merged;
          state_d = StWr;
        end
      end
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      acc_q   <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from the state register so an asynchronous reset
  // drops mem_we immediately, aborting any pending write.
  always_comb begin
    req_ready  = (state_q == StIdle);
    mem_en     = (state_q == StRd) || (state_q == StWr);
    mem_we     = (state_q == StWr);
    mem_addr   = addr_q[ADDR_W+1:2];
    mem_wdata  = (q_dec.size == SzW) ? wdata_q : data_q;
    resp_valid = (state_q == StResp);
    resp_err   = (state_q == StResp) && err_q;
    resp_rdata = '0;
    if (state_q == StResp) begin
      if (err_q) begin
        resp_rdata = ERR_RDATA;
      end else if (q_dec.load) begin
        resp_rdata = data_q;
      end
    end
  end

`ifdef DMEM_STAT_EN
  logic [31:0] ld_cnt_q, st_cnt_q, rmw_cnt_q, err_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_cnt_q  <= '0;
      st_cnt_q  <= '0;
      rmw_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (state_q == StResp) begin
      if (err_q) begin
        err_cnt_q <= sat_inc(err_cnt_q);
      end else if (q_dec.load) begin
        ld_cnt_q <= sat_inc(ld_cnt_q);
      end else begin
        st_cnt_q <= sat_inc(st_cnt_q);
        if (q_dec.size != SzW) begin
          rmw_cnt_q <= sat_inc(rmw_cnt_q);
        end
      end
    end
  end

  assign stat_ld  = ld_cnt_q;
  assign stat_st  = st_cnt_q;
  assign stat_rmw = rmw_cnt_q;
  assign stat_err = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Self-checking bench for dmem_port_ctrl: a synchronous RAM model drives
// mem_rdata, a reference memory plus an arithmetic access model predicts
// every response, write word, RAM traffic count and latency.

module tb_dmem_port_ctrl;

  localparam int unsigned ADDR_W = 10;
  localparam logic [31:0] ERR_V  = 32'hBADD_0000;

  logic              clk;
  logic              rstn;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [3:0]        req_access;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
`ifdef DMEM_STAT_EN
  logic [31:0] stat_ld, stat_st, stat_rmw, stat_err;
  int e_ld, e_st, e_rmw, e_err;
`endif

  dmem_port_ctrl #(
    .ADDR_W    (ADDR_W),
    .ERR_RDATA (ERR_V)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_access (req_access),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_STAT_EN
    ,
    .stat_ld    (stat_ld),
    .stat_st    (stat_st),
    .stat_rmw   (stat_rmw),
    .stat_err   (stat_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] ram     [1024];
  logic [31:0] ref_mem [1024];
  logic        tb_we = 1'b0;
  logic [9:0]  tb_wa = '0;
  logic [31:0] tb_wd = '0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [9:0]  last_addr = '0;
  logic [31:0] last_wdata = '0;
  bit          in_txn = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with a bench-side backdoor write port.
  always @(posedge clk) begin
    if (tb_we) begin
      ram[tb_wa] <= tb_wd;
    end else if (mem_en) begin
      last_addr <= mem_addr;
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        wr_cnt        <= wr_cnt + 1;
        last_wdata    <= mem_wdata;
      end else begin
        mem_rdata <= ram[mem_addr];
        rd_cnt    <= rd_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Between transactions the port must sit idle.
  always @(posedge clk) begin
    #2;
    if (rstn && !in_txn) begin
      chk("idle_ready", {31'b0, req_ready}, 32'd1);
      chk("idle_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("idle_mem_en", {31'b0, mem_en}, 32'd0);
    end
  end

  // Reference model: outcome of one access against ref_mem.
  function automatic void model(input logic [31:0] a, input logic [3:0] c,
                                input logic [31:0] wd, output logic e,
                                output logic [31:0] rd, output int lat, output int nrd,
                                output int nwr, output logic [31:0] nw);
    int sz, sh;
    bit ld, sg;
    longint unsigned w, m, v;
    w = 64'(ref_mem[a[11:2]]);
    e = 1'b0; rd = '0; nw = ref_mem[a[11:2]]; nrd = 0; nwr = 0; lat = 0;
    ld = 1'b0; sg = 1'b0; sz = 0;
    case (c)
      4'b0110: begin sz = 4; ld = 1; end
      4'b0001: begin sz = 1; ld = 1; end
      4'b0010: begin sz = 1; ld = 1; sg = 1; end
      4'b0100: begin sz = 2; ld = 1; end
      4'b1000: begin sz = 2; ld = 1; sg = 1; end
      4'b1001: sz = 4;
      4'b0011: sz = 1;
      4'b1100: sz = 2;
      default: sz = 0;
    endcase
    if (sz == 0 || (int'(a % 4) % sz) != 0) begin
      e = 1'b1; rd = ERR_V; lat = 1;
      return;
    end
    sh = int'(a % 4) * 8;
    m  = (64'd1 << (8 * sz)) - 1;
    if (ld) begin
      v = (w >> sh) & m;
      if (sg && (((v >> (8 * sz - 1)) & 1) == 1)) v = v | (64'hFFFF_FFFF & ~m);
      rd = v[31:0]; lat = 3; nrd = 1;
    end else if (sz == 4) begin
      nw = wd; lat = 2; nwr = 1;
    end else begin
      v  = (w & ~(m << sh)) | ((64'(wd) & m) << sh);
      nw = v[31:0]; lat = 4; nrd = 1; nwr = 1;
    end
  endfunction

  task automatic bd_write(input logic [9:0] wa, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = wa; tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
    ref_mem[wa] = d;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [3:0] c, input logic [31:0] wd);
    logic e;
    logic [31:0] rd, nw;
    int lat, nrd, nwr, got, r0, w0;
    logic [9:0] wa;
    wa = a[11:2];
    model(a, c, wd, e, rd, lat, nrd, nwr, nw);
    in_txn = 1'b1;
    @(negedge clk);
    chk("accept_ready", {31'b0, req_ready}, 32'd1);
    r0 = rd_cnt; w0 = wr_cnt;
    req_valid = 1'b1; req_addr = a; req_access = c; req_wdata = wd;
    @(posedge clk);
    #1;
    // Keep valid high with junk while busy; it must not be sampled.
    req_addr = $urandom; req_access = 4'($urandom); req_wdata = $urandom;
    got = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = i;
        break;
      end
      chk("busy_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    chk("latency", got, lat);
    chk("resp_err", {31'b0, resp_err}, {31'b0, e});
    chk("resp_rdata", resp_rdata, rd);
    @(negedge clk);
    chk("resp_one_cycle", {31'b0, resp_valid}, 32'd0);
    chk("ready_after", {31'b0, req_ready}, 32'd1);
    chk("ram_reads", rd_cnt - r0, nrd);
    chk("ram_writes", wr_cnt - w0, nwr);
    if (nrd + nwr > 0) chk("mem_addr", {22'b0, last_addr}, {22'b0, wa});
    if (nwr > 0) chk("mem_wdata", last_wdata, nw);
    if (!e && nwr > 0) ref_mem[wa] = nw;
    chk("ram_word", ram[wa], ref_mem[wa]);
`ifdef DMEM_STAT_EN
    if (e) e_err++;
    else if (nwr == 0) e_ld++;
    else begin
      e_st++;
      if (nrd > 0) e_rmw++;
    end
`endif
    in_txn = 1'b0;
  endtask

  // Pin the model to hand-computed values, then run the access on the DUT.
  task automatic pin(input logic [31:0] a, input logic [3:0] c, input logic [31:0] wd,
                     input logic [31:0] x_rd, input logic x_e, input int x_lat,
                     input logic [31:0] x_nw);
    logic e;
    logic [31:0] rd, nw;
    int lat, nrd, nwr;
    model(a, c, wd, e, rd, lat, nrd, nwr, nw);
    chk("pin_rdata", rd, x_rd);
    chk("pin_err", {31'b0, e}, {31'b0, x_e});
    chk("pin_lat", lat, x_lat);
    if (nwr > 0) chk("pin_word", nw, x_nw);
    do_req(a, c, wd);
  endtask

  logic [3:0] legal_codes [8];
  int         w0m;

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    legal_codes = '{4'b1001, 4'b0110, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1000, 4'b1100};
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    rstn = 1'b0; req_valid = 1'b0; req_addr = '0; req_access = '0; req_wdata = '0;
`ifdef DMEM_STAT_EN
    e_ld = 0; e_st = 0; e_rmw = 0; e_err = 0;
`endif
    #12;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    for (int i = 0; i < 16; i++) bd_write(10'(i), $urandom);
    bd_write(10'd1, 32'h8899AABB);
    @(negedge clk);
    rstn = 1'b1;
    in_txn = 1'b0;
    repeat (2) @(negedge clk);

    pin(32'h5, 4'b0010, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 32'h0);
    pin(32'h6, 4'b0100, 32'h0, 32'h00008899, 1'b0, 3, 32'h0);
    pin(32'h4, 4'b0110, 32'h0, 32'h8899AABB, 1'b0, 3, 32'h0);
    pin(32'h5, 4'b0011, 32'h12, 32'h0, 1'b0, 4, 32'h889912BB);
    pin(32'h4, 4'b0110, 32'h0, 32'h889912BB, 1'b0, 3, 32'h0);
    bd_write(10'd1, 32'h8899AABB);
    pin(32'h6, 4'b1100, 32'hFFFF1234, 32'h0, 1'b0, 4, 32'h1234AABB);
    pin(32'h8, 4'b1001, 32'hDEADBEEF, 32'h0, 1'b0, 2, 32'hDEADBEEF);
    pin(32'h5, 4'b1000, 32'h0, ERR_V, 1'b1, 1, 32'h0);
    pin(32'h0, 4'b0111, 32'h0, ERR_V, 1'b1, 1, 32'h0);

    // Abort an st_b with reset while it waits in the read-data cycle.
    in_txn = 1'b1;
    @(negedge clk);
    w0m = wr_cnt;
    req_valid = 1'b1; req_addr = 32'h5; req_access = 4'b0011; req_wdata = 32'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_we", {31'b0, mem_we}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_resp_valid2", {31'b0, resp_valid}, 32'd0);
    chk("abort_no_write", wr_cnt - w0m, 32'd0);
    chk("abort_ram", ram[1], ref_mem[1]);
`ifdef DMEM_STAT_EN
    e_ld = 0; e_st = 0; e_rmw = 0; e_err = 0;
`endif
    in_txn = 1'b0;

    for (int n = 0; n < 300; n++) begin
      logic [3:0] c;
      if ($urandom_range(0, 3) != 0) c = legal_codes[$urandom_range(0, 7)];
      else c = 4'($urandom);
      do_req(32'($urandom_range(0, 63)), c, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef DMEM_STAT_EN
    chk("stat_ld", stat_ld, e_ld);
    chk("stat_st", stat_st, e_st);
    chk("stat_rmw", stat_rmw, e_rmw);
    chk("stat_err", stat_err, e_err);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
